// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the saturating counter update used by the pattern-history table.
package bp_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,  // strongly not-taken
    CtrWnt = 2'b01,  // weakly not-taken (reset value)
    CtrWt  = 2'b10,  // weakly taken
    CtrSt  = 2'b11   // strongly taken
  } ctr_e;

  // Move one step toward the resolved outcome, sticking at either end.
  function automatic ctr_e satUpdate(ctr_e ctr, logic taken);
    ctr_e nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CtrSt) nxt = ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != CtrSnt) nxt = ctr_e'(ctr - 2'd1);
    end
    return nxt;
  endfunction

  // Prediction is the counter MSB.
  function automatic logic predTaken(ctr_e ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern-history table: 2^IDX_W saturating 2-bit counters with one
// combinational read port and one synchronous read-modify-write port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rdIdx,
  output ctr_e             rdCtr,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrTaken
);

  localparam int unsigned Entries = 1 << IDX_W;

  ctr_e ctrArr [Entries];

  // Read returns the stored value; a same-cycle write is not bypassed.
  assign rdCtr = ctrArr[rdIdx];

  // Counter storage: reset all entries to weakly not-taken, else train one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        ctrArr[i] <= CtrWnt;
      end
    end else if (wrEn) begin
      ctrArr[wrIdx] <= satUpdate(ctrArr[wrIdx], wrTaken);
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch prediction controller: bimodal 2-bit predictor looked up in fetch,
// resolved and trained in decode, with saturating statistics counters.
// Optional feature: define BP_GSHARE_EN to XOR a global history register
// into the table index (gshare).
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned PHT_BITS = 6,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pcF,
  input  logic              stallD,
  input  logic              branchD,
  input  logic              takenD,
  output logic              pred_takenF,
  output logic              pred_takenD,
  output logic              mispredictD,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  logic [PHT_BITS-1:0] pcIdx;
  logic [PHT_BITS-1:0] idxF;
  logic [PHT_BITS-1:0] idxD;
  logic                validD;
  logic                update;
  ctr_e                ctrF;

  assign pcIdx = pcF[PHT_BITS+1:2];

  // Word-offset and high PC bits do not take part in indexing.
  logic unusedPcBits;
  assign unusedPcBits = ^{pcF[31:PHT_BITS+2], pcF[1:0]};

`ifdef BP_GSHARE_EN
  logic [PHT_BITS-1:0] ghr;

  assign idxF = pcIdx ^ ghr;

  // Global history: shifted only by resolved branches, never speculatively.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (update) begin
      ghr <= {ghr[PHT_BITS-2:0], takenD};
    end
  end
`else
  assign idxF = pcIdx;
`endif

  assign update      = validD & branchD & ~stallD;
  assign mispredictD = update & (takenD ^ pred_takenD);
  assign pred_takenF = predTaken(ctrF);

  bp_pht #(
    .IDX_W (PHT_BITS)
  ) u_pht (
    .clk     (clk),
    .rst     (rst),
    .rdIdx   (idxF),
    .rdCtr   (ctrF),
    .wrEn    (update),
    .wrIdx   (idxD),
    .wrTaken (takenD)
  );

  // Decode register: carries the fetch-time prediction and index; a redirect
  // squashes the wrong-path slot being fetched alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      validD      <= 1'b0;
      pred_takenD <= 1'b0;
      idxD        <= '0;
    end else if (!stallD) begin
      if (mispredictD) begin
        validD      <= 1'b0;
        pred_takenD <= 1'b0;
        idxD        <= '0;
      end else begin
        validD      <= 1'b1;
        pred_takenD <= pred_takenF;
        idxD        <= idxF;
      end
    end
  end

  // Statistics: count resolved branches and mispredictions, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (update) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + STAT_W'(1);
      if (mispredictD && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed vector table, a counter
// saturation sequence on a narrow-statistics instance, and randomized traffic
// checked against a behavioural predictor model.
module tb_branch_pred_ctrl;

  localparam int PB = 6;
  localparam int NE = 1 << PB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        stallD, branchD, takenD;

  logic        predF, predD, mis;
  logic [31:0] brCnt, misCnt;
  logic        predFS, predDS, misS;
  logic [3:0]  brCntS, misCntS;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_pred_ctrl #(.PHT_BITS(PB), .STAT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcF         (pcF),
    .stallD      (stallD),
    .branchD     (branchD),
    .takenD      (takenD),
    .pred_takenF (predF),
    .pred_takenD (predD),
    .mispredictD (mis),
    .branch_cnt  (brCnt),
    .mispred_cnt (misCnt)
  );

  branch_pred_ctrl #(.PHT_BITS(PB), .STAT_W(4)) dutS (
    .clk         (clk),
    .rst         (rst),
    .pcF         (pcF),
    .stallD      (stallD),
    .branchD     (branchD),
    .takenD      (takenD),
    .pred_takenF (predFS),
    .pred_takenD (predDS),
    .mispredictD (misS),
    .branch_cnt  (brCntS),
    .mispred_cnt (misCntS)
  );

  // Reference model: table of counter values 0..3, one decode slot, counts.
  int     mPht [NE];
  bit     mValid;
  bit     mPred;
  int     mIdx;
  longint mBr, mMc;
  int     mGhr;
  bit     synced = 0;

  function automatic int idxOf(logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % NE);
`ifdef BP_GSHARE_EN
    i = i ^ mGhr;
`endif
    return i;
  endfunction

  function automatic longint satTo(longint v, longint maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observed outputs of the most recent cycle, for table comparisons.
  logic   oF, oD, oM;
  longint oBr, oMc, oBrS;

  // One clock cycle: drive, sample mid-cycle, optionally compare to model, advance model.
  task automatic step(input logic r, input logic [31:0] pc, input logic s, input logic b,
                      input logic t, input bit modelChk);
    int  iF;
    bit  eF, eM, res;
    rst = r; pcF = pc; stallD = s; branchD = b; takenD = t;
    @(negedge clk);
    iF  = idxOf(pc);
    eF  = mPht[iF] >= 2;
    res = mValid && b && !s;
    eM  = res && (t != mPred);
    oF = predF; oD = predD; oM = mis;
    oBr = longint'(brCnt); oMc = longint'(misCnt); oBrS = longint'(brCntS);
    if (modelChk && synced && !r) begin
      check("predF", longint'(predF), longint'(eF));
      check("predD", longint'(predD), longint'(mValid ? mPred : 1'b0));
      check("mispredict", longint'(mis), longint'(eM));
      check("branchCnt", longint'(brCnt), satTo(mBr, 64'hFFFF_FFFF));
      check("mispredCnt", longint'(misCnt), satTo(mMc, 64'hFFFF_FFFF));
      check("branchCnt4", longint'(brCntS), satTo(mBr, 15));
      check("mispredCnt4", longint'(misCntS), satTo(mMc, 15));
      check("predF4", longint'(predFS), longint'(eF));
    end
    if (r) begin
      for (int i = 0; i < NE; i++) mPht[i] = 1;
      mValid = 0; mPred = 0; mIdx = 0; mBr = 0; mMc = 0; mGhr = 0;
      synced = 1;
    end else begin
      if (res) begin
        if (t) mPht[mIdx] = (mPht[mIdx] == 3) ? 3 : mPht[mIdx] + 1;
        else   mPht[mIdx] = (mPht[mIdx] == 0) ? 0 : mPht[mIdx] - 1;
        mBr++;
        if (eM) mMc++;
        mGhr = ((mGhr << 1) | int'(t)) % NE;
      end
      if (!s) begin
        if (eM) begin
          mValid = 0; mPred = 0; mIdx = 0;
        end else begin
          mValid = 1; mPred = eF; mIdx = iF;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [31:0] pc;
    logic        s, b, t;
    bit          chk;
    logic        eF, eD, eM;
    int          eBr, eMc;
  } vec_t;

  function automatic vec_t mk(logic r, logic [31:0] pc, logic s, logic b, logic t, bit chk,
                              logic eF, logic eD, logic eM, int eBr, int eMc);
    vec_t v;
    v.r = r; v.pc = pc; v.s = s; v.b = b; v.t = t; v.chk = chk;
    v.eF = eF; v.eD = eD; v.eM = eM; v.eBr = eBr; v.eMc = eMc;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    rst = 1'b1; pcF = '0; stallD = 1'b0; branchD = 1'b0; takenD = 1'b0;

`ifndef BP_GSHARE_EN
    //             rst pc          st br tk chk  F  D  M  br mc
    vecs[0]  = mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset
    vecs[1]  = mk(0, 32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // reset state visible
    vecs[2]  = mk(0, 32'h40, 0, 1, 1, 1, 0, 0, 1, 0, 0);  // first taken: mispredict
    vecs[3]  = mk(0, 32'h40, 0, 1, 1, 1, 1, 0, 0, 1, 1);  // squashed slot, no update
    vecs[4]  = mk(0, 32'h40, 0, 1, 1, 1, 1, 1, 0, 1, 1);  // second taken: correct
    vecs[5]  = mk(0, 32'h80, 1, 1, 1, 1, 0, 1, 0, 2, 1);  // stall x3: all held
    vecs[6]  = mk(0, 32'h80, 1, 1, 1, 1, 0, 1, 0, 2, 1);
    vecs[7]  = mk(0, 32'h80, 1, 1, 1, 1, 0, 1, 0, 2, 1);
    vecs[8]  = mk(0, 32'h80, 0, 1, 0, 1, 0, 1, 1, 2, 1);  // not-taken vs predicted taken
    vecs[9]  = mk(0, 32'h80, 0, 1, 0, 1, 0, 0, 0, 3, 2);  // squashed, no update
    vecs[10] = mk(0, 32'h40, 0, 0, 0, 1, 1, 0, 0, 3, 2);  // entry 16 now 10
    vecs[11] = mk(0, 32'h40, 0, 0, 0, 1, 1, 1, 0, 3, 2);
    vecs[12] = mk(1, 32'h40, 0, 1, 0, 0, 0, 0, 0, 0, 0);  // reset mid-operation
    vecs[13] = mk(0, 32'h40, 0, 1, 1, 1, 0, 0, 0, 0, 0);  // clean after reset
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].r, vecs[i].pc, vecs[i].s, vecs[i].b, vecs[i].t, 1'b0);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d.predF", i), longint'(oF), longint'(vecs[i].eF));
        check($sformatf("vec%0d.predD", i), longint'(oD), longint'(vecs[i].eD));
        check($sformatf("vec%0d.mispredict", i), longint'(oM), longint'(vecs[i].eM));
        check($sformatf("vec%0d.branchCnt", i), oBr, longint'(vecs[i].eBr));
        check($sformatf("vec%0d.mispredCnt", i), oMc, longint'(vecs[i].eMc));
      end
    end
`else
    // History pattern T,N,T: each resolution preceded by a fill cycle so the slot is valid.
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h40, 1'b0, 1'b1, (k != 1), 1'b1);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1);
`endif

    // Statistics saturation on the 4-bit instance.
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b0, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1);
    check("branchCnt4.saturated", longint'(brCntS), 15);
    check("branchCnt.resolved", longint'(brCnt), mBr);

    // Randomized traffic against the model.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 800; k++) begin
      logic [31:0] pc;
      pc = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      step(($urandom_range(0, 99) == 0), pc, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
